// File: rtl/eip_redirect_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : eip_redirect_ctrl_if
// Description : Bundles the writeback, decode, exception and fetch-redirect
//               signals around the EIP redirect controller. The master
//               modport drives the stage inputs. The slave modport is the
//               controller itself. The redir_cnt/exc_cnt statistics signals
//               exist only when EIP_REDIRECT_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface eip_redirect_ctrl_if;
    logic        wb_valid;
    logic        wb_eip_change;
    logic [31:0] wb_target;
    logic        wb_pr_size_over;
    logic        de_valid;
    logic        de_stall;
    logic [31:0] de_eip_next;
    logic        exc_req;
    logic [31:0] exc_vector;
    logic        fe_redir_ready;
    logic [31:0] eip;
    logic [1:0]  eip_ld_sel;
    logic        fe_redir_valid;
    logic [31:0] fe_redir_addr;
    logic        flush_fe_de;
    logic        busy;
`ifdef EIP_REDIRECT_CNT_EN
    logic [15:0] redir_cnt;
    logic [15:0] exc_cnt;
`endif

    modport master (
        output wb_valid, wb_eip_change, wb_target, wb_pr_size_over,
        output de_valid, de_stall, de_eip_next,
        output exc_req, exc_vector, fe_redir_ready,
`ifdef EIP_REDIRECT_CNT_EN
        input  redir_cnt, exc_cnt,
`endif
        input  eip, eip_ld_sel, fe_redir_valid, fe_redir_addr, flush_fe_de, busy
    );

    modport slave (
        input  wb_valid, wb_eip_change, wb_target, wb_pr_size_over,
        input  de_valid, de_stall, de_eip_next,
        input  exc_req, exc_vector, fe_redir_ready,
`ifdef EIP_REDIRECT_CNT_EN
        output redir_cnt, exc_cnt,
`endif
        output eip, eip_ld_sel, fe_redir_valid, fe_redir_addr, flush_fe_de, busy
    );
endinterface
`default_nettype wire

// File: rtl/eip_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : eip_redirect_ctrl
// Description : Writeback-stage owner of the architectural EIP. Each cycle it
//               arbitrates between three sources, listed from highest to
//               lowest priority: exception vector, writeback redirect and
//               sequential decode advance. On a redirect it flushes
//               fetch/decode. It then holds a valid/ready redirect request to
//               fetch, and drains for DRAIN_CYCLES cycles before normal
//               advance resumes.
//               Optional: EIP_REDIRECT_CNT_EN adds saturating redirect and
//               exception counters.
// Revision    : 1.0 - initial release
// ============================================================================
module eip_redirect_ctrl #(
    parameter logic [31:0] RESET_EIP    = 32'h0000_0000,
    parameter int          DRAIN_CYCLES = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    eip_redirect_ctrl_if.slave  bus
);

    localparam logic [3:0] DRAIN_LD = DRAIN_CYCLES[3:0];

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_DEC  = 2'b01;
    localparam logic [1:0] SEL_WB   = 2'b10;
    localparam logic [1:0] SEL_EXC  = 2'b11;

    typedef enum logic [1:0] {
        BOOT      = 2'd0,
        RUN       = 2'd1,
        REDIR_REQ = 2'd2,
        DRAIN     = 2'd3
    } state_t;

    state_t      state;
    logic [3:0]  drain_cnt;
    logic [31:0] eip;
    logic [31:0] redir_addr;
    logic        redir_valid;
    logic        flush;

    logic [1:0]  ld_sel;
    logic [31:0] sel_addr;
    logic        redirect_taken;

    wire logic        wb_redir = bus.wb_valid & bus.wb_eip_change;
    wire logic [31:0] wb_tgt   = bus.wb_pr_size_over ? {16'h0000, bus.wb_target[15:0]}
                                                     : bus.wb_target;

    // Fixed-priority source select. BOOT ignores every source because it
    // always fetches from RESET_EIP. Decode advance is only honoured in RUN.
    always_comb begin
        ld_sel   = SEL_HOLD;
        sel_addr = bus.exc_vector;
        if (state != BOOT) begin
            if (bus.exc_req) begin
                ld_sel   = SEL_EXC;
                sel_addr = bus.exc_vector;
            end else if (wb_redir) begin
                ld_sel   = SEL_WB;
                sel_addr = wb_tgt;
            end else if (bus.de_valid && !bus.de_stall && state == RUN) begin
                ld_sel   = SEL_DEC;
                sel_addr = bus.de_eip_next;
            end
        end
    end

    assign redirect_taken = ld_sel[1];

    // Control-flow state machine with all of its registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            drain_cnt   <= 4'd0;
            eip         <= RESET_EIP;
            redir_addr  <= RESET_EIP;
            redir_valid <= 1'b0;
            flush       <= 1'b0;
        end else begin
            flush <= 1'b0;
            case (state)
                BOOT: begin
                    state       <= REDIR_REQ;
                    redir_valid <= 1'b1;
                    redir_addr  <= RESET_EIP;
                end
                RUN, DRAIN: begin
                    if (redirect_taken) begin
                        eip         <= sel_addr;
                        redir_addr  <= sel_addr;
                        redir_valid <= 1'b1;
                        flush       <= 1'b1;
                        drain_cnt   <= 4'd0;
                        state       <= REDIR_REQ;
                    end else if (state == RUN) begin
                        if (ld_sel == SEL_DEC) begin
                            eip <= sel_addr;
                        end
                    end else if (drain_cnt <= 4'd1) begin
                        drain_cnt <= 4'd0;
                        state     <= RUN;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                REDIR_REQ: begin
                    // The newest redirect replaces a pending one. Fetch
                    // samples the address only on valid & ready.
                    if (redirect_taken) begin
                        eip        <= sel_addr;
                        redir_addr <= sel_addr;
                        flush      <= 1'b1;
                    end else if (bus.fe_redir_ready) begin
                        redir_valid <= 1'b0;
                        if (DRAIN_LD == 4'd0) begin
                            state <= RUN;
                        end else begin
                            drain_cnt <= DRAIN_LD;
                            state     <= DRAIN;
                        end
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    assign bus.eip            = eip;
    assign bus.eip_ld_sel     = ld_sel;
    assign bus.fe_redir_valid = redir_valid;
    assign bus.fe_redir_addr  = redir_addr;
    assign bus.flush_fe_de    = flush;
    assign bus.busy           = (state != RUN);

`ifdef EIP_REDIRECT_CNT_EN
    logic [15:0] redir_cnt;
    logic [15:0] exc_cnt;

    // Saturating counts of accepted writeback redirects and exceptions,
    // including overrides while a request is pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            redir_cnt <= 16'h0000;
            exc_cnt   <= 16'h0000;
        end else begin
            if (ld_sel == SEL_WB && redir_cnt != 16'hFFFF) begin
                redir_cnt <= redir_cnt + 16'h0001;
            end
            if (ld_sel == SEL_EXC && exc_cnt != 16'hFFFF) begin
                exc_cnt <= exc_cnt + 16'h0001;
            end
        end
    end

    assign bus.redir_cnt = redir_cnt;
    assign bus.exc_cnt   = exc_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eip_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_eip_redirect_ctrl
// Description : Directed bench for eip_redirect_ctrl with RESET_EIP = 32'h1000
//               and DRAIN_CYCLES = 2. Counter checks are active when
//               EIP_REDIRECT_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eip_redirect_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    eip_redirect_ctrl_if bus ();

    eip_redirect_ctrl #(
        .RESET_EIP    (32'h0000_1000),
        .DRAIN_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_eip"},   bus.eip, 32'h0000_1000);
        chk({tag, "_valid"}, 32'(bus.fe_redir_valid), 32'd0);
        chk({tag, "_addr"},  bus.fe_redir_addr, 32'h0000_1000);
        chk({tag, "_flush"}, 32'(bus.flush_fe_de), 32'd0);
        chk({tag, "_busy"},  32'(bus.busy), 32'd1);
`ifdef EIP_REDIRECT_CNT_EN
        chk({tag, "_rcnt"},  32'(bus.redir_cnt), 32'd0);
        chk({tag, "_ecnt"},  32'(bus.exc_cnt), 32'd0);
`endif
    endtask

    initial begin
        bus.wb_valid        = 1'b0;
        bus.wb_eip_change   = 1'b0;
        bus.wb_target       = 32'h0;
        bus.wb_pr_size_over = 1'b0;
        bus.de_valid        = 1'b0;
        bus.de_stall        = 1'b0;
        bus.de_eip_next     = 32'h0;
        bus.exc_req         = 1'b0;
        bus.exc_vector      = 32'h0;
        bus.fe_redir_ready  = 1'b1;

        // Reset state
        step();
        step();
        chk_reset("reset");

        // Boot: redirect to RESET_EIP without a flush, then drain 2 cycles
        rst = 1'b0;
        step();
        chk("boot_valid", 32'(bus.fe_redir_valid), 32'd1);
        chk("boot_addr",  bus.fe_redir_addr, 32'h0000_1000);
        chk("boot_flush", 32'(bus.flush_fe_de), 32'd0);
        step();
        chk("boot_hs_valid", 32'(bus.fe_redir_valid), 32'd0);
        chk("boot_drain1_busy", 32'(bus.busy), 32'd1);
        step();
        chk("boot_drain2_busy", 32'(bus.busy), 32'd1);
        chk("boot_drain_flush", 32'(bus.flush_fe_de), 32'd0);
        step();
        chk("boot_run_busy", 32'(bus.busy), 32'd0);

        // Decode advance, then a stalled decode
        bus.de_valid    = 1'b1;
        bus.de_eip_next = 32'h0000_1004;
        #1;
        chk("dec_sel", 32'(bus.eip_ld_sel), 32'd1);
        step();
        chk("dec_eip", bus.eip, 32'h0000_1004);
        bus.de_stall    = 1'b1;
        bus.de_eip_next = 32'h0000_1008;
        #1;
        chk("stall_sel", 32'(bus.eip_ld_sel), 32'd0);
        step();
        chk("stall_eip", bus.eip, 32'h0000_1004);
        bus.de_valid = 1'b0;
        bus.de_stall = 1'b0;

        // 16-bit masked writeback redirect, with fetch not ready for 3 cycles
        bus.fe_redir_ready  = 1'b0;
        bus.wb_valid        = 1'b1;
        bus.wb_eip_change   = 1'b1;
        bus.wb_target       = 32'h0001_2345;
        bus.wb_pr_size_over = 1'b1;
        #1;
        chk("wb_sel", 32'(bus.eip_ld_sel), 32'd2);
        step();
        bus.wb_valid        = 1'b0;
        bus.wb_eip_change   = 1'b0;
        bus.wb_pr_size_over = 1'b0;
        chk("wb_eip",   bus.eip, 32'h0000_2345);
        chk("wb_addr",  bus.fe_redir_addr, 32'h0000_2345);
        chk("wb_valid", 32'(bus.fe_redir_valid), 32'd1);
        chk("wb_flush", 32'(bus.flush_fe_de), 32'd1);
        chk("wb_busy",  32'(bus.busy), 32'd1);
        bus.de_valid    = 1'b1;
        bus.de_eip_next = 32'h0000_DEAD;
        #1;
        chk("req_dec_sel", 32'(bus.eip_ld_sel), 32'd0);
        step();
        bus.de_valid = 1'b0;
        chk("wb_flush_once", 32'(bus.flush_fe_de), 32'd0);
        chk("req_dec_eip", bus.eip, 32'h0000_2345);
        chk("wb_valid2", 32'(bus.fe_redir_valid), 32'd1);
        step();
        chk("wb_valid3", 32'(bus.fe_redir_valid), 32'd1);
        bus.fe_redir_ready = 1'b1;
        step();
        chk("wb_hs_valid", 32'(bus.fe_redir_valid), 32'd0);
        chk("wb_drain1_busy", 32'(bus.busy), 32'd1);
        step();
        chk("wb_drain2_busy", 32'(bus.busy), 32'd1);
        step();
        chk("wb_run_busy", 32'(bus.busy), 32'd0);

        // Exception and writeback redirect in the same cycle: exception wins
        bus.fe_redir_ready = 1'b0;
        bus.exc_req        = 1'b1;
        bus.exc_vector     = 32'h0000_8000;
        bus.wb_valid       = 1'b1;
        bus.wb_eip_change  = 1'b1;
        bus.wb_target      = 32'h0000_2000;
        #1;
        chk("both_sel", 32'(bus.eip_ld_sel), 32'd3);
        step();
        bus.exc_req       = 1'b0;
        bus.wb_valid      = 1'b0;
        bus.wb_eip_change = 1'b0;
        chk("both_eip",   bus.eip, 32'h0000_8000);
        chk("both_addr",  bus.fe_redir_addr, 32'h0000_8000);
        chk("both_flush", 32'(bus.flush_fe_de), 32'd1);

        // Pending request overridden by a writeback redirect to 32'h2000
        bus.wb_valid      = 1'b1;
        bus.wb_eip_change = 1'b1;
        #1;
        chk("ovr_wb_sel", 32'(bus.eip_ld_sel), 32'd2);
        step();
        bus.wb_valid      = 1'b0;
        bus.wb_eip_change = 1'b0;
        chk("ovr_wb_addr",  bus.fe_redir_addr, 32'h0000_2000);
        chk("ovr_wb_flush", 32'(bus.flush_fe_de), 32'd1);
        step();
        chk("ovr_gap_flush", 32'(bus.flush_fe_de), 32'd0);
        chk("ovr_gap_valid", 32'(bus.fe_redir_valid), 32'd1);

        // Pending request to 32'h2000 overridden by an exception
        bus.exc_req = 1'b1;
        step();
        bus.exc_req = 1'b0;
        chk("ovr_exc_addr",  bus.fe_redir_addr, 32'h0000_8000);
        chk("ovr_exc_eip",   bus.eip, 32'h0000_8000);
        chk("ovr_exc_flush", 32'(bus.flush_fe_de), 32'd1);
        chk("ovr_exc_valid", 32'(bus.fe_redir_valid), 32'd1);
`ifdef EIP_REDIRECT_CNT_EN
        chk("cnt_redir", 32'(bus.redir_cnt), 32'd2);
        chk("cnt_exc",   32'(bus.exc_cnt), 32'd2);
`endif

        // Handshake completes, then reset is asserted during DRAIN
        bus.fe_redir_ready = 1'b1;
        step();
        chk("exc_hs_valid", 32'(bus.fe_redir_valid), 32'd0);
        step();
        chk("drain_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        step();
        chk_reset("rst_drain");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
